cp0_irq_ctrl: RTL and testbench

//  Parametrised coprocessor-0 interrupt controller, successor to the single-line c0 register block.
//  - Synchronises NUM_IRQ external interrupt lines and latches them as pending, edge- or level-mode per line.
//  - Masks pending lines against STATUS, picks one winner by fixed priority and runs a req/ack handshake

---
 rtl/cp0_irq_ctrl_if.sv | 29 ++
 rtl/cp0_irq_ctrl.sv | 141 ++++++++++++++
 tb/tb_cp0_irq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_irq_ctrl_if.sv
// CP0 interrupt controller <-> pipeline bundle.
// master: pipeline side; slave: controller side.
interface cp0_irq_ctrl_if;
  logic        pipe_ready;
  logic [31:0] pc_if;
  logic        int_req;
  logic        int_ack;
  logic [2:0]  irq_id;
  logic [31:0] handler_pc;
  logic        eret;
  logic [31:0] epc;
  logic        mtc0_en;
  logic [4:0]  mtc0_sel;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_sel;
  logic [31:0] mfc0_data;

  modport master (
    output pipe_ready, pc_if, int_ack, eret,
    output mtc0_en, mtc0_sel, mtc0_data, mfc0_sel,
    input  int_req, irq_id, handler_pc, epc, mfc0_data
  );

  modport slave (
    input  pipe_ready, pc_if, int_ack, eret,
    input  mtc0_en, mtc0_sel, mtc0_data, mfc0_sel,
    output int_req, irq_id, handler_pc, epc, mfc0_data
  );
endinterface

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: sync + pending latch, fixed-priority
// arbitration, req/ack to the PC mux, STATUS/CAUSE/EPC via mtc0/mfc0.
// Ports: clk, rst (async, active-high), irq_in[NUM_IRQ], bus (slave).
module cp0_irq_ctrl #(
  parameter int          NUM_IRQ     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  EDGE_MASK   = 8'hFF,
  parameter logic [31:0] HANDLER_PC  = 32'h0000_0004
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  cp0_irq_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [NUM_IRQ-1:0] EDGE = EDGE_MASK[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync, sync_d_q, rise;
  logic [NUM_IRQ-1:0] ip_q, ip_d, im_q, clr, eligible;
  logic [7:0]         elig8;
  logic               ie_q, exl_q, exl_d;
  logic [2:0]         irq_id_q, last_id_q, win;
  logic [31:0]        epc_q, status_rd, cause_rd;
  logic               wr_status, wr_cause, wr_epc;
  logic               fire, held, take, enter;
  state_t             state_q, state_d;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign rise      = sync & ~sync_d_q;
  assign wr_status = bus.mtc0_en && bus.mtc0_sel == 5'd12;
  assign wr_cause  = bus.mtc0_en && bus.mtc0_sel == 5'd13;
  assign wr_epc    = bus.mtc0_en && bus.mtc0_sel == 5'd14;
  assign eligible  = ip_q & im_q;
  assign elig8     = 8'(eligible);
  assign held      = elig8[irq_id_q];
  assign fire      = ie_q & ~exl_q & (|eligible) & bus.pipe_ready;

  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (eligible[i]) win = 3'(i);
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    enter   = 1'b0;
    unique case (state_q)
      IDLE: if (fire) begin
        state_d = REQ;
        enter   = 1'b1;
      end
      REQ: if (bus.int_ack) begin
        state_d = SERVICE;
        take    = 1'b1;
      end else if (!held || !ie_q) begin
        state_d = IDLE;
      end
      SERVICE: if (bus.eret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge lines: a new rising edge beats any clear in the same cycle.
  always_comb begin
    clr = '0;
    if (take) clr = NUM_IRQ'(8'b1 << irq_id_q);
    if (wr_cause) clr = clr | bus.mtc0_data[8+:NUM_IRQ];
    ip_d = (EDGE & ((ip_q & ~clr) | rise)) | (~EDGE & sync);
  end

  // Ack forces EXL even over a same-cycle STATUS write.
  always_comb begin
    exl_d = exl_q;
    if (wr_status) exl_d = bus.mtc0_data[1];
    if (bus.eret) exl_d = 1'b0;
    if (take) exl_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      sync_d_q  <= '0;
      ip_q      <= '0;
      im_q      <= '0;
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      irq_id_q  <= '0;
      last_id_q <= '0;
      epc_q     <= '0;
      state_q   <= IDLE;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sync_d_q <= sync;
      ip_q     <= ip_d;
      exl_q    <= exl_d;
      state_q  <= state_d;
      if (wr_status) begin
        ie_q <= bus.mtc0_data[0];
        im_q <= bus.mtc0_data[8+:NUM_IRQ];
      end
      if (enter) irq_id_q <= win;
      if (take) begin
        last_id_q <= irq_id_q;
        epc_q     <= bus.pc_if;
      end else if (wr_epc) begin
        epc_q <= bus.mtc0_data;
      end
    end
  end

  always_comb begin
    status_rd              = '0;
    status_rd[0]           = ie_q;
    status_rd[1]           = exl_q;
    status_rd[8+:NUM_IRQ]  = im_q;
    cause_rd               = '0;
    cause_rd[8+:NUM_IRQ]   = ip_q;
    cause_rd[31:29]        = last_id_q;
  end

  always_comb begin
    bus.mfc0_data = '0;
    unique case (1'b1)
      bus.mfc0_sel == 5'd12: bus.mfc0_data = status_rd;
      bus.mfc0_sel == 5'd13: bus.mfc0_data = cause_rd;
      bus.mfc0_sel == 5'd14: bus.mfc0_data = epc_q;
      default:               bus.mfc0_data = '0;
    endcase
  end

  assign bus.int_req    = state_q == REQ;
  assign bus.irq_id     = irq_id_q;
  assign bus.epc        = epc_q;
  assign bus.handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Testbench for cp0_irq_ctrl: directed scenarios plus random
// traffic against a behavioural model of the CP0 interrupt rules.
module tb_cp0_irq_ctrl;
  localparam int         N  = 8;
  localparam int         S  = 2;
  localparam logic [7:0] EM = 8'hF7;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_in;
  cp0_irq_ctrl_if bus ();

  cp0_irq_ctrl #(
    .NUM_IRQ(N), .SYNC_STAGES(S),
    .EDGE_MASK(EM), .HANDLER_PC(32'h0000_0004)
  ) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // model: hist[0] = irq_in sampled at the most recent edge
  logic [N-1:0] hist [S+1];
  int           m_mode;  // 0 idle, 1 requesting, 2 in handler
  logic [N-1:0] m_ip, m_im;
  logic         m_ie, m_exl;
  logic [2:0]   m_id, m_last;
  logic [31:0]  m_epc;

  task automatic model_reset();
    for (int k = 0; k <= S; k++) hist[k] = '0;
    m_mode = 0; m_ip = '0; m_im = '0; m_ie = 0; m_exl = 0;
    m_id = '0; m_last = '0; m_epc = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] sel);
    logic [31:0] v = '0;
    if (sel == 5'd12) v = {16'b0, m_im, 6'b0, m_exl, m_ie};
    if (sel == 5'd13) v = {m_last, 13'b0, m_ip, 8'b0};
    if (sel == 5'd14) v = m_epc;
    return v;
  endfunction

  task automatic model_edge();
    logic [N-1:0] sy, syd, elig, n_ip, n_im;
    logic         n_ie, n_exl;
    logic [2:0]   n_id, n_last, w;
    logic [31:0]  n_epc;
    int           n_mode;
    bit           fire, wr_s, wr_c, wr_e, acked;
    sy = hist[S-1]; syd = hist[S];
    elig = m_ip & m_im;
    w = 0;
    for (int i = N - 1; i >= 0; i--) if (elig[i]) w = 3'(i);
    fire = m_ie && !m_exl && elig != 0 && bus.pipe_ready;
    wr_s = bus.mtc0_en && bus.mtc0_sel == 5'd12;
    wr_c = bus.mtc0_en && bus.mtc0_sel == 5'd13;
    wr_e = bus.mtc0_en && bus.mtc0_sel == 5'd14;
    acked = m_mode == 1 && bus.int_ack;
    n_ip = m_ip; n_im = m_im; n_ie = m_ie; n_exl = m_exl;
    n_id = m_id; n_last = m_last; n_epc = m_epc; n_mode = m_mode;
    for (int i = 0; i < N; i++) begin
      if (!EM[i]) n_ip[i] = sy[i];
      else if (sy[i] && !syd[i]) n_ip[i] = 1'b1;
      else if ((acked && int'(m_id) == i) ||
               (wr_c && bus.mtc0_data[8+i])) n_ip[i] = 1'b0;
    end
    if (wr_s) begin
      n_ie = bus.mtc0_data[0];
      n_exl = bus.mtc0_data[1];
      n_im = bus.mtc0_data[15:8];
    end
    if (bus.eret) n_exl = 1'b0;
    if (wr_e) n_epc = bus.mtc0_data;
    if (m_mode == 0 && fire) begin
      n_mode = 1; n_id = w;
    end else if (acked) begin
      n_mode = 2; n_epc = bus.pc_if; n_exl = 1'b1; n_last = m_id;
    end else if (m_mode == 1 && (!elig[m_id] || !m_ie)) begin
      n_mode = 0;
    end else if (m_mode == 2 && bus.eret) begin
      n_mode = 0;
    end
    for (int k = S; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = irq_in;
    m_ip = n_ip; m_im = n_im; m_ie = n_ie; m_exl = n_exl;
    m_id = n_id; m_last = n_last; m_epc = n_epc; m_mode = n_mode;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("int_req", 32'(bus.int_req), 32'(m_mode == 1));
    if (m_mode == 1) chk("irq_id", 32'(bus.irq_id), 32'(m_id));
    chk("epc", bus.epc, m_epc);
    chk("mfc0", bus.mfc0_data, model_read(bus.mfc0_sel));
  endtask

  task automatic rd(input logic [4:0] sel, output logic [31:0] v);
    bus.mfc0_sel = sel;
    #1;
    v = bus.mfc0_data;
  endtask

  task automatic mtc0(input logic [4:0] sel, input logic [31:0] d);
    bus.mtc0_en = 1'b1; bus.mtc0_sel = sel; bus.mtc0_data = d;
    tick();
    bus.mtc0_en = 1'b0;
  endtask

  task automatic ack(input logic [31:0] pc);
    bus.pc_if = pc; bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic do_eret();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int lim);
    int n = 0;
    while (!bus.int_req && n < lim) begin
      tick();
      n++;
    end
    chk({tag, "_wait"}, 32'(bus.int_req), 32'd1);
  endtask

  logic [31:0] v;

  initial begin
    rst = 1'b1; irq_in = '0;
    bus.pipe_ready = 1'b1; bus.pc_if = '0; bus.int_ack = 1'b0;
    bus.eret = 1'b0; bus.mtc0_en = 1'b0; bus.mtc0_sel = '0;
    bus.mtc0_data = '0; bus.mfc0_sel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req", 32'(bus.int_req), 32'd0);
    chk("rst_id", 32'(bus.irq_id), 32'd0);
    chk("rst_hpc", bus.handler_pc, 32'h4);
    rd(12, v); chk("rst_status", v, 32'h0);
    rd(13, v); chk("rst_cause", v, 32'h0);
    rd(14, v); chk("rst_epc", v, 32'h0);

    // 1: single edge pulse, latency and ack
    mtc0(12, 32'h0000_0101);
    irq_in = 8'h01; tick(); irq_in = '0;
    tick(); chk("t1_e1", 32'(bus.int_req), 32'd0);
    tick(); chk("t1_e2", 32'(bus.int_req), 32'd0);
    tick(); chk("t1_e3", 32'(bus.int_req), 32'd1);
    chk("t1_id", 32'(bus.irq_id), 32'd0);
    ack(32'h40);
    chk("t1_epc", bus.epc, 32'h40);
    rd(12, v); chk("t1_status", v, 32'h103);
    rd(13, v); chk("t1_ip0", 32'(v[8]), 32'd0);
    do_eret();

    // 2: priority, then the loser after eret
    mtc0(12, 32'h0000_FF01);
    irq_in = 8'h24; tick(); irq_in = '0;
    wait_req("t2a", 8);
    chk("t2_id2", 32'(bus.irq_id), 32'd2);
    ack(32'h100);
    do_eret();
    chk("t2_gap", 32'(bus.int_req), 32'd0);
    wait_req("t2b", 8);
    chk("t2_id5", 32'(bus.irq_id), 32'd5);
    rd(13, v); chk("t2_last", 32'(v[31:29]), 32'd2);
    ack(32'h104);
    do_eret();

    // 3: level line 3
    irq_in = 8'h08;
    wait_req("t3a", 8);
    chk("t3_id", 32'(bus.irq_id), 32'd3);
    ack(32'h200);
    tick();
    rd(13, v); chk("t3_ip_held", 32'(v[11]), 32'd1);
    do_eret();
    chk("t3_gap", 32'(bus.int_req), 32'd0);
    tick();
    chk("t3_rereq", 32'(bus.int_req), 32'd1);
    ack(32'h204);
    irq_in = '0;
    tick(); tick();
    rd(13, v); chk("t3_ip_2", 32'(v[11]), 32'd1);
    tick();
    rd(13, v); chk("t3_ip_3", 32'(v[11]), 32'd0);
    do_eret();

    // 4: withdraw by masking the winner
    irq_in = 8'h02; tick(); irq_in = '0;
    wait_req("t4a", 8);
    chk("t4_id", 32'(bus.irq_id), 32'd1);
    mtc0(12, 32'h0000_FD01);
    chk("t4_still", 32'(bus.int_req), 32'd1);
    tick();
    chk("t4_drop", 32'(bus.int_req), 32'd0);
    chk("t4_epc", bus.epc, 32'h204);
    tick();
    chk("t4_idle", 32'(bus.int_req), 32'd0);
    mtc0(12, 32'h0000_FF01);
    wait_req("t4b", 8);
    ack(32'h300);
    do_eret();

    // 5: pipe_ready gating
    bus.pipe_ready = 1'b0;
    irq_in = 8'h40; tick(); irq_in = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_blocked", 32'(bus.int_req), 32'd0);
    end
    bus.pipe_ready = 1'b1;
    tick();
    chk("t5_req", 32'(bus.int_req), 32'd1);
    chk("t5_id", 32'(bus.irq_id), 32'd6);
    ack(32'h400);
    do_eret();

    // 6: reset mid-handshake
    irq_in = 8'h10; tick(); irq_in = '0;
    wait_req("t6a", 8);
    #2 rst = 1'b1;
    #1 chk("t6_req", 32'(bus.int_req), 32'd0);
    rd(12, v); chk("t6_status", v, 32'h0);
    rd(13, v); chk("t6_cause", v, 32'h0);
    rd(14, v); chk("t6_epc", v, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    mtc0(12, 32'h0000_FF01);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0)
        irq_in = irq_in ^ N'(1 << $urandom_range(0, N - 1));
      bus.pipe_ready = $urandom_range(0, 9) != 0;
      bus.pc_if = $urandom;
      bus.int_ack = (m_mode == 1 && $urandom_range(0, 2) == 0) ||
                    $urandom_range(0, 29) == 0;
      bus.eret = (m_mode == 2 && $urandom_range(0, 2) == 0) ||
                 $urandom_range(0, 39) == 0;
      bus.mtc0_en = $urandom_range(0, 9) == 0;
      case ($urandom_range(0, 3))
        0: bus.mtc0_sel = 5'd12;
        1: bus.mtc0_sel = 5'd13;
        2: bus.mtc0_sel = 5'd14;
        default: bus.mtc0_sel = 5'd7;
      endcase
      bus.mtc0_data = $urandom;
      if (bus.mtc0_sel == 5'd12 && $urandom_range(0, 4) != 0)
        bus.mtc0_data = (bus.mtc0_data & ~32'h2) | 32'h1;
      case ($urandom_range(0, 4))
        0: bus.mfc0_sel = 5'd12;
        1: bus.mfc0_sel = 5'd13;
        2: bus.mfc0_sel = 5'd14;
        3: bus.mfc0_sel = 5'd0;
        default: bus.mfc0_sel = 5'd21;
      endcase
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
